// File: rtl/div32_seq_if.sv
// rtl/div32_seq_if.sv - start/busy/done handshake bundle between control unit and divider
//
// Purpose: groups the divider request (start, signedOp, A, B) and the result
// (busy, done, Q, R, divZero) into one interface.
//   master : control unit side, drives start/signedOp/A/B, observes results
//   slave  : divider side, observes request, drives busy/done/Q/R/divZero
interface div32_seq_if;
  logic        start;
  logic        signedOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] Q;
  logic [31:0] R;
  logic        divZero;

  modport master (
    output start, signedOp, A, B,
    input  busy, done, Q, R, divZero
  );

  modport slave (
    input  start, signedOp, A, B,
    output busy, done, Q, R, divZero
  );
endinterface

// File: rtl/div32_seq.sv
// rtl/div32_seq.sv - multi-cycle 32-bit signed/unsigned restoring divider
//
// Purpose: computes Q = A / B and R = A % B one quotient bit per cycle.
// Signed mode truncates toward zero; the remainder takes the dividend's sign.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (aborts any divide, clears outputs)
//   bus   : div32_seq_if.slave
//           start/signedOp/A/B in; busy/done/Q/R/divZero out (all registered)
// A divide with B != 0 takes 33 cycles (busy for 33, done pulse on the 33rd
// edge after acceptance); B == 0 reports done one edge later with busy low.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  div32_seq_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [4:0]       count;
  logic [WIDTH-1:0] rem;      // partial remainder
  logic [WIDTH-1:0] dvd;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs;      // divisor magnitude
  logic             qneg;
  logic             rneg;
  logic             dz_pend;  // divide-by-zero accepted, result due next edge

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   shifted;  // {rem, next dividend bit}, can exceed 32 bits
  logic [WIDTH+1:0] trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_nx;

  always_comb begin
    abs_a = (bus.signedOp && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    abs_b = (bus.signedOp && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    shifted = {rem, dvd[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, dvs};
    borrow  = trial[WIDTH+1];
    // On borrow the shifted value is below the divisor, so it fits WIDTH bits.
    rem_nx  = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      rem         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      qneg        <= 1'b0;
      rneg        <= 1'b0;
      dz_pend     <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.Q       <= '0;
      bus.R       <= '0;
      bus.divZero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (dz_pend) begin
            // dvd holds the raw dividend captured on the accepting edge
            bus.Q       <= '1;
            bus.R       <= dvd;
            bus.divZero <= 1'b1;
            bus.done    <= 1'b1;
            dz_pend     <= 1'b0;
          end else if (bus.start) begin
            if (bus.B == '0) begin
              dvd     <= bus.A;
              dz_pend <= 1'b1;
            end else begin
              dvd      <= abs_a;
              dvs      <= abs_b;
              qneg     <= bus.signedOp & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
              rneg     <= bus.signedOp & bus.A[WIDTH-1];
              rem      <= '0;
              count    <= 5'd31;
              bus.busy <= 1'b1;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          rem   <= rem_nx;
          dvd   <= {dvd[WIDTH-2:0], ~borrow};
          count <= count - 5'd1;
          if (count == 5'd0) state <= FIX;
        end
        FIX: begin
          bus.Q       <= qneg ? -dvd : dvd;
          bus.R       <= rneg ? -rem : rem;
          bus.done    <= 1'b1;
          bus.divZero <= 1'b0;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// tb/tb_div32_seq.sv - scoreboard bench for div32_seq
module tb_div32_seq;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  int   busy_run;
  int   last_busy_len;
  int   busy_seen;
  logic prev_done;

  div32_seq_if bus ();

  div32_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every done pulse against the oldest expected result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.busy) begin
        busy_run++;
        busy_seen = 1;
      end else if (busy_run > 0) begin
        last_busy_len = busy_run;
        busy_run = 0;
      end
      if (bus.done) begin
        check("done_not_back_to_back", {31'd0, prev_done}, 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("Q", bus.Q, e.q);
          check("R", bus.R, e.r);
          check("divZero", {31'd0, bus.divZero}, {31'd0, e.dz});
          check("done_cycle", cyc, e.cyc);
        end
      end
      prev_done = bus.done;
    end else begin
      busy_run  = 0;
      prev_done = 1'b0;
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after a rising edge; start is sampled on the next edge (E0).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz,
                       output int e0);
    exp_t e;
    e0 = cyc + 1;
    e.q = eq;
    e.r = er;
    e.dz = edz;
    e.cyc = e0 + (edz ? 1 : 33);
    sb.push_back(e);
    bus.A = a;
    bus.B = b;
    bus.signedOp = s;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    bus.signedOp = 1'($urandom);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  int e0;
  int e0b;

  initial begin
    cyc = 0;
    n_checks = 0;
    n_fail = 0;
    busy_run = 0;
    last_busy_len = 0;
    busy_seen = 0;
    prev_done = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.signedOp = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_Q", bus.Q, 0);
    check("rst_R", bus.R, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    check("rst_divZero", {31'd0, bus.divZero}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Unsigned basic, plus busy length
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, e0);
    drain(100);
    check("busy_len", last_busy_len, 33);

    // Signed and edge-value vectors
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, e0); drain(100);
    issue(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, e0);        drain(100);
    issue(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0, e0); drain(100);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, e0); drain(100);
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, e0);        drain(100);
    issue(32'd3, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd3, 1'b0, e0);                drain(100);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, e0); drain(100);
    issue(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, e0);        drain(100);

    // Divide by zero in both modes: 1-cycle latency, busy never set
    busy_seen = 0;
    issue(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, e0); drain(10);
    issue(32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, e0); drain(10);
    check("dz_busy_never", busy_seen, 0);

    // Handshake: mid-run start ignored, held start accepted at E0+34
    issue(32'd1000, 32'd7, 1'b0, 32'd142, 32'd6, 1'b0, e0);
    wait_cyc(e0 + 9);
    bus.A = 32'd9; bus.B = 32'd3; bus.signedOp = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_cyc(e0 + 30);
    begin
      exp_t e;
      e.q = 32'd22; e.r = 32'd2; e.dz = 1'b0; e.cyc = e0 + 67;
      sb.push_back(e);
    end
    bus.A = 32'd200; bus.B = 32'd9; bus.signedOp = 1'b0; bus.start = 1'b1;
    wait_cyc(e0 + 34);
    bus.start = 1'b0;
    drain(100);

    // Reset mid-operation
    issue(32'd12345, 32'd10, 1'b0, 32'd1234, 32'd5, 1'b0, e0);
    wait_cyc(e0 + 14);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_Q", bus.Q, 0);
    check("midrst_R", bus.R, 0);
    check("midrst_busy", {31'd0, bus.busy}, 0);
    check("midrst_done", {31'd0, bus.done}, 0);
    check("midrst_divZero", {31'd0, bus.divZero}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, e0b);
    drain(100);
    repeat (5) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
